// File: rtl/multi_ctrl.sv
// Main control FSM of the multi-cycle MIPS core: Moore sequencer for fetch, decode,
// execute, memory and write-back, with a MemReady stall handshake on memory states.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FETCH   | read instruction at PC, load IR and PC+4 when memory ready
// DECODE  | register read, branch target into ALUOut
// MEMADR  | effective address A + imm for lw/sw
// MEMRD   | data memory read at ALUOut, wait for MemReady
// MEMWB   | write loaded data to rt
// MEMWR   | data memory write at ALUOut, wait for MemReady
// EXEC    | R-type ALU operation selected by Func
// RWB     | write R-type result to rd
// BEQ     | compare A-B, redirect PC to ALUOut on Zero
// JUMP    | load PC with jump target
// ADDIEX  | A + imm for addi
// ADDIWB  | write addi result to rt

module multi_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] Op,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUop,
   output logic [1:0] PCSource,
   output logic       InstrDone,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BEQ    = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   state_t state;
   state_t state_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_FETCH;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = S_FETCH;
      case (state)
         S_FETCH:  state_nxt = MemReady ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (Op)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_R:         state_nxt = S_EXEC;
               OP_BEQ:       state_nxt = S_BEQ;
               OP_J:         state_nxt = S_JUMP;
               OP_ADDI:      state_nxt = S_ADDIEX;
               default:      state_nxt = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            // Op is held by the IR, so anything other than lw/sw here is unreachable
            if (Op == OP_LW)
               state_nxt = S_MEMRD;
            else if (Op == OP_SW)
               state_nxt = S_MEMWR;
            else
               state_nxt = S_FETCH;
         end
         S_MEMRD:  state_nxt = MemReady ? S_MEMWB : S_MEMRD;
         S_MEMWR:  state_nxt = MemReady ? S_FETCH : S_MEMWR;
         S_EXEC:   state_nxt = S_RWB;
         S_ADDIEX: state_nxt = S_ADDIWB;
         default:  state_nxt = S_FETCH;
      endcase
   end

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUop       = 2'b00;
      PCSource    = 2'b00;
      InstrDone   = 1'b0;
      case (state)
         S_FETCH: begin
            MemRead = 1'b1;
            IRWrite = MemReady;
            PCWrite = MemReady;
            ALUSrcB = 2'b01;
         end
         S_DECODE: ALUSrcB = 2'b11;
         S_MEMADR, S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWR: begin
            MemWrite  = 1'b1;
            IorD      = 1'b1;
            InstrDone = MemReady;
         end
         S_MEMWB: begin
            RegWrite  = 1'b1;
            MemtoReg  = 1'b1;
            InstrDone = 1'b1;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUop   = 2'b10;
         end
         S_RWB: begin
            RegWrite  = 1'b1;
            RegDst    = 1'b1;
            InstrDone = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA     = 1'b1;
            ALUop       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            InstrDone   = 1'b1;
         end
         S_JUMP: begin
            PCWrite   = 1'b1;
            PCSource  = 2'b10;
            InstrDone = 1'b1;
         end
         S_ADDIWB: begin
            RegWrite  = 1'b1;
            InstrDone = 1'b1;
         end
         default: ;
      endcase
      // Reset blanks every enable immediately, so nothing half-issued leaks out
      if (rst) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         IorD        = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         MemtoReg    = 1'b0;
         RegDst      = 1'b0;
         RegWrite    = 1'b0;
         ALUSrcA     = 1'b0;
         ALUSrcB     = 2'b00;
         ALUop       = 2'b00;
         PCSource    = 2'b00;
         InstrDone   = 1'b0;
      end
   end

   assign State = state;

endmodule

// File: doc/multi_ctrl.md
# multi_ctrl

Main control unit of the multi-cycle MIPS processor: a Moore state machine that decodes the instruction opcode and sequences fetch, decode, execute, memory and write-back over 3–5 cycles per instruction. It drives the datapath enables and muxes and produces the 2-bit `ALUop` consumed by the downstream ALU-control decoder, which combines `ALUop` with the instruction Func field. It supports R-type, lw, sw, beq, j and addi, plus a memory-ready stall handshake.

## Interface
- No parameters.
- `clk` — input, 1 — single system clock; all state changes on the rising edge.
- `rst` — input, 1 — asynchronous, active-high reset.
- `Op` — input, 6 — opcode, IR[31:26]; valid from DECODE onward.
- `MemReady` — input, 1 — memory completed the current access; tie to 1 for ideal memory.
- `PCWrite`, `PCWriteCond` — output, 1 each — unconditional PC write; PC write qualified by ALU Zero.
- `IorD` — output, 1 — memory address select: 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite`, `IRWrite` — output, 1 each — memory read, memory write, and IR load enable.
- `MemtoReg`, `RegDst`, `RegWrite` — output, 1 each — register-file write-data select, destination select (1 = rd), and write enable.
- `ALUSrcA` — output, 1 — ALU A select: 0 = PC, 1 = register A.
- `ALUSrcB` — output, 2 — ALU B select: 00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `ALUop` — output, 2 — to ALU control: 00 = add, 01 = sub, 10 = use Func.
- `PCSource` — output, 2 — PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `InstrDone` — output, 1 — high during the final cycle of each instruction.
- `State` — output, 4 — current state, exposed for debug.

## Operation
- **State encodings:** FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9, ADDIEX=10, ADDIWB=11. Encodings 12–15 are illegal and go to FETCH on the next edge with all outputs 0.
- **Opcodes:**
  - R = 000000
  - lw = 100011
  - sw = 101011
  - beq = 000100
  - j = 000010
  - addi = 001000
- **Output default:** every output not listed for a state is 0.
- **Per-state outputs:**
  - FETCH: MemRead=1, IRWrite=MemReady, PCWrite=MemReady, ALUSrcB=01, ALUop=00, PCSource=00, IorD=0.
  - DECODE: ALUSrcB=11, ALUop=00 (computes the branch target).
  - MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUop=00.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWR: MemWrite=1, IorD=1, InstrDone=MemReady.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, InstrDone=1.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUop=10.
  - RWB: RegWrite=1, RegDst=1, MemtoReg=0, InstrDone=1.
  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUop=01, PCWriteCond=1, PCSource=01, InstrDone=1.
  - JUMP: PCWrite=1, PCSource=10, InstrDone=1.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0, InstrDone=1.
- **Transitions:**
  - FETCH → DECODE if MemReady, else stay in FETCH.
  - DECODE → by opcode: lw/sw → MEMADR; R → EXEC; beq → BEQ; j → JUMP; addi → ADDIEX; any other opcode → FETCH (instruction dropped, no side effects).
  - MEMADR → MEMRD if lw, MEMWR if sw.
  - MEMRD → MEMWB if MemReady, else stay.
  - MEMWR → FETCH if MemReady, else stay.
  - EXEC → RWB; ADDIEX → ADDIWB.
  - MEMWB, RWB, BEQ, JUMP, ADDIWB → FETCH.
- **Combinational paths:** outputs depend on the state register only, except for the MemReady qualification in FETCH and MEMWR. There is no path from `Op` to any output.

## Timing
- **Reset:** while `rst` is high, the state is FETCH and all outputs are forced to 0 combinationally. `State` reads 0.
  - The first FETCH outputs appear in the cycle after `rst` falls.
  - Reset asserted mid-instruction returns to FETCH immediately; no partially completed writes are issued after assertion.
- **Latency with MemReady=1, counted from FETCH to the InstrDone cycle inclusive:** lw 5 cycles, sw 4, R 4, addi 4, beq 3, j 3. Unknown opcode takes 2 cycles with no InstrDone.
- **Stalls:** each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds one cycle. All outputs hold during the stall, with PCWrite and IRWrite held at 0 in FETCH.
- **Op sampling:** `Op` is sampled only on the DECODE→next edge and in MEMADR. `Op` must be stable from DECODE through the last cycle of the instruction, which the IR guarantees because IRWrite is 0 outside FETCH.
- **InstrDone:** exactly one cycle per completed instruction.

## Test plan
- **Reset:** assert `rst` mid-EXEC → outputs 0 and State=0 immediately. Release `rst` → next cycle MemRead=1, ALUSrcB=01, PCWrite=1.
- **R-type:** Op=000000, MemReady=1 → State sequence 0,1,6,7,0. ALUop=10 in EXEC; RegWrite=1 and RegDst=1 in RWB; InstrDone high only in RWB.
- **lw with stalls:** Op=100011, MemReady=0 for 2 cycles in FETCH and 3 cycles in MEMRD → total 10 cycles. IRWrite pulses once; MemtoReg=1 and RegWrite=1 in MEMWB.
- **sw:** Op=101011 → State 0,1,2,5,0. MemWrite=1 and IorD=1 in MEMWR; RegWrite never asserted.
- **beq / j / addi:**
  - beq → State 0,1,8 with ALUop=01, PCWriteCond=1, PCSource=01.
  - j → State 0,1,9 with PCWrite=1, PCSource=10.
  - addi → State 0,1,10,11 with ALUSrcB=10, then RegWrite=1 and RegDst=0.
- **Illegal opcode:** Op=111111 → State 0,1,0 with no write enables asserted and InstrDone=0. A forced State=13 returns to 0 on the next edge.
